// File: rtl/temp_sensor_3wire_ctrl.sv
// temp_sensor_3wire_ctrl: controller for NUM_CH temperature sensors that share
// one 3-wire serial bus (SC/SIO). Each sensor has its own chip select.
// A transaction reads DATA_W bits and can optionally write a CMD_W-bit
// command afterwards. Transactions are started manually, or by round-robin
// polling when auto_en is set.
// Optional feature macro: TEMP_ALARM_EN adds the thr_hi, thr_lo and
// alarm_clr ports and sticky per-channel threshold alarms. When the macro is
// not defined, alarm is tied to zero.
// The tri-state SIO pad buffer is instantiated above this block.
module temp_sensor_3wire_ctrl #(
    parameter int CLK_DIV     = 25,
    parameter int DATA_W      = 16,
    parameter int CMD_W       = 16,
    parameter int NUM_CH      = 4,
    parameter int POLL_CYCLES = 5000000
) (
    input  logic                     clk_50,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [2:0]               ch_sel,
    input  logic                     cmd_wr,
    input  logic [CMD_W-1:0]         cmd,
    input  logic                     auto_en,
    output logic                     busy,
    output logic [NUM_CH-1:0]        cs_n,
    output logic                     sc,
    output logic                     sio_o,
    output logic                     sio_oe,
    input  logic                     sio_i,
    output logic [DATA_W-1:0]        rd_data,
    output logic [2:0]               rd_ch,
    output logic                     rd_valid,
`ifdef TEMP_ALARM_EN
    input  logic signed [DATA_W-1:0] thr_hi,
    input  logic signed [DATA_W-1:0] thr_lo,
    input  logic                     alarm_clr,
`endif
    output logic [NUM_CH-1:0]        alarm
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int MAX_W  = (DATA_W > CMD_W) ? DATA_W : CMD_W;
    localparam int BIT_W  = $clog2(MAX_W) + 1;
    localparam int POLL_W = $clog2(POLL_CYCLES) + 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  RD_LAST   = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  WR_LAST   = BIT_W'(CMD_W - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);
    localparam logic [2:0]        PTR_LAST  = 3'(NUM_CH - 1);
    localparam logic [3:0]        NUM_CH_W  = 4'(NUM_CH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    state_t              state_q;
    logic [DIV_W-1:0]    div_cnt_q;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic [POLL_W-1:0]   poll_cnt_q;
    logic [2:0]          ptr_q;
    logic [2:0]          ch_q;
    logic                wr_q;
    logic                auto_txn_q;
    logic [CMD_W-1:0]    cmd_q;
    logic [DATA_W-1:0]   shift_q;
    logic                busy_q;
    logic [NUM_CH-1:0]   cs_n_q;
    logic                sc_q;
    logic                sio_o_q;
    logic                sio_oe_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic [2:0]          rd_ch_q;
    logic                rd_valid_q;

    logic                half_done_s;
    logic                manual_go_s;
    logic                poll_go_s;

    // Active-low chip-select pattern with only the chosen channel driven low
    function automatic logic [NUM_CH-1:0] cs_pattern(input logic [2:0] ch);
        logic [NUM_CH-1:0] pat;
        for (int i = 0; i < NUM_CH; i++) begin
            pat[i] = (3'(i) != ch);
        end
        return pat;
    endfunction

    // Launch qualifiers and the SC half-period terminal count
    always_comb begin
        half_done_s = (div_cnt_q == DIV_LAST);
        poll_go_s   = auto_en && (poll_cnt_q == POLL_LAST);
        if (!auto_en && start && ({1'b0, ch_sel} < NUM_CH_W)) begin
            manual_go_s = 1'b1;
        end else begin
            manual_go_s = 1'b0;
        end
    end

    // Transaction FSM; it also produces every registered bus and result output
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            poll_cnt_q <= '0;
            ptr_q      <= 3'd0;
            ch_q       <= 3'd0;
            wr_q       <= 1'b0;
            auto_txn_q <= 1'b0;
            cmd_q      <= '0;
            shift_q    <= '0;
            busy_q     <= 1'b0;
            cs_n_q     <= '1;
            sc_q       <= 1'b0;
            sio_o_q    <= 1'b0;
            sio_oe_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_ch_q    <= 3'd0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    div_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    sc_q      <= 1'b0;
                    if (poll_go_s) begin
                        state_q    <= ST_SETUP;
                        busy_q     <= 1'b1;
                        cs_n_q     <= cs_pattern(ptr_q);
                        ch_q       <= ptr_q;
                        wr_q       <= 1'b0;
                        cmd_q      <= '0;
                        auto_txn_q <= 1'b1;
                        poll_cnt_q <= '0;
                    end else if (manual_go_s) begin
                        state_q    <= ST_SETUP;
                        busy_q     <= 1'b1;
                        cs_n_q     <= cs_pattern(ch_sel);
                        ch_q       <= ch_sel;
                        wr_q       <= cmd_wr;
                        cmd_q      <= cmd;
                        auto_txn_q <= 1'b0;
                        poll_cnt_q <= '0;
                    end else if (auto_en) begin
                        poll_cnt_q <= poll_cnt_q + POLL_W'(1);
                    end else begin
                        poll_cnt_q <= '0;
                    end
                end
                ST_SETUP: begin
                    if (half_done_s) begin
                        div_cnt_q <= '0;
                        state_q   <= ST_READ;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                ST_READ: begin
                    if (!half_done_s) begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end else if (!sc_q) begin
                        // SC rising: capture the sensor bit
                        div_cnt_q <= '0;
                        sc_q      <= 1'b1;
                        shift_q   <= {shift_q[DATA_W-2:0], sio_i};
                    end else begin
                        div_cnt_q <= '0;
                        sc_q      <= 1'b0;
                        if (bit_cnt_q != RD_LAST) begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end else if (wr_q) begin
                            // The first command bit goes out on the same falling edge
                            bit_cnt_q <= '0;
                            state_q   <= ST_WRITE;
                            sio_oe_q  <= 1'b1;
                            sio_o_q   <= cmd_q[CMD_W-1];
                            cmd_q     <= {cmd_q[CMD_W-2:0], 1'b0};
                        end else begin
                            bit_cnt_q <= '0;
                            state_q   <= ST_HOLD;
                        end
                    end
                end
                ST_WRITE: begin
                    if (!half_done_s) begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end else if (!sc_q) begin
                        div_cnt_q <= '0;
                        sc_q      <= 1'b1;
                    end else begin
                        div_cnt_q <= '0;
                        sc_q      <= 1'b0;
                        if (bit_cnt_q == WR_LAST) begin
                            bit_cnt_q <= '0;
                            state_q   <= ST_HOLD;
                            sio_oe_q  <= 1'b0;
                            sio_o_q   <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            sio_o_q   <= cmd_q[CMD_W-1];
                            cmd_q     <= {cmd_q[CMD_W-2:0], 1'b0};
                        end
                    end
                end
                ST_HOLD: begin
                    if (half_done_s) begin
                        div_cnt_q  <= '0;
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        cs_n_q     <= '1;
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= shift_q;
                        rd_ch_q    <= ch_q;
                        if (!auto_txn_q) begin
                            ptr_q <= ptr_q;
                        end else if (ptr_q == PTR_LAST) begin
                            ptr_q <= 3'd0;
                        end else begin
                            ptr_q <= ptr_q + 3'd1;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                    cs_n_q   <= '1;
                    sc_q     <= 1'b0;
                    sio_o_q  <= 1'b0;
                    sio_oe_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign cs_n     = cs_n_q;
    assign sc       = sc_q;
    assign sio_o    = sio_o_q;
    assign sio_oe   = sio_oe_q;
    assign rd_data  = rd_data_q;
    assign rd_ch    = rd_ch_q;
    assign rd_valid = rd_valid_q;

`ifdef TEMP_ALARM_EN
    logic [NUM_CH-1:0] alarm_q;
    logic [NUM_CH-1:0] alarm_set_s;
    logic              hit_s;

    // Out-of-range detection on each delivered word, steered to its channel
    always_comb begin
        alarm_set_s = '0;
        hit_s = ($signed(rd_data_q) > thr_hi) || ($signed(rd_data_q) < thr_lo);
        if (rd_valid_q && hit_s) begin
            for (int i = 0; i < NUM_CH; i++) begin
                alarm_set_s[i] = (3'(i) == rd_ch_q);
            end
        end else begin
            alarm_set_s = '0;
        end
    end

    // Sticky alarms; a new set wins over a same-cycle clear
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            alarm_q <= '0;
        end else if (alarm_clr) begin
            alarm_q <= alarm_set_s;
        end else begin
            alarm_q <= alarm_q | alarm_set_s;
        end
    end

    assign alarm = alarm_q;
`else
    assign alarm = '0;
`endif

endmodule

// File: tb/tb_temp_sensor_3wire_ctrl.sv
// Directed bench for temp_sensor_3wire_ctrl with CLK_DIV=2, 16-bit words,
// 4 channels and POLL_CYCLES=100. A behavioural sensor shifts out a preset
// word on SIO and collects the command bits that follow it.
module tb_temp_sensor_3wire_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  ch_sel;
    logic        cmd_wr;
    logic [15:0] cmd;
    logic        auto_en;
    logic        busy;
    logic [3:0]  cs_n;
    logic        sc;
    logic        sio_o;
    logic        sio_oe;
    logic        sio_i = 1'b0;
    logic [15:0] rd_data;
    logic [2:0]  rd_ch;
    logic        rd_valid;
    logic [3:0]  alarm;
`ifdef TEMP_ALARM_EN
    logic signed [15:0] thr_hi;
    logic signed [15:0] thr_lo;
    logic               alarm_clr;
`endif

    int checks = 0;
    int errors = 0;

    temp_sensor_3wire_ctrl #(
        .CLK_DIV(2), .DATA_W(16), .CMD_W(16), .NUM_CH(4), .POLL_CYCLES(100)
    ) dut (
        .clk_50(clk), .reset_n(reset_n), .start(start), .ch_sel(ch_sel),
        .cmd_wr(cmd_wr), .cmd(cmd), .auto_en(auto_en), .busy(busy),
        .cs_n(cs_n), .sc(sc), .sio_o(sio_o), .sio_oe(sio_oe), .sio_i(sio_i),
        .rd_data(rd_data), .rd_ch(rd_ch), .rd_valid(rd_valid),
`ifdef TEMP_ALARM_EN
        .thr_hi(thr_hi), .thr_lo(thr_lo), .alarm_clr(alarm_clr),
`endif
        .alarm(alarm)
    );

    always #5 clk = ~clk;

    // Sensor model state
    logic [15:0] sens_word = 16'h0000;
    logic [15:0] cmd_cap   = 16'h0000;
    int          rises     = 0;
    int          oe_bad    = 0;
    logic        prev_sc   = 1'b0;
    logic        prev_idle = 1'b1;

    // Sensor model: drives read bits and samples command bits on SC rises
    always @(negedge clk) begin
        if (prev_idle && !(&cs_n)) begin
            rises   = 0;
            oe_bad  = 0;
            cmd_cap = 16'h0000;
            prev_sc = 1'b0;
        end
        if (!(&cs_n) && sc && !prev_sc) begin
            rises = rises + 1;
            if (rises > 16) begin
                cmd_cap = {cmd_cap[14:0], sio_o};
                if (!sio_oe) oe_bad = oe_bad + 1;
            end else if (sio_oe) begin
                oe_bad = oe_bad + 1;
            end
        end
        prev_sc   = sc;
        prev_idle = &cs_n;
        sio_i     = (rises < 16) ? sens_word[4'(15 - rises)] : 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Manual transaction; lat counts from the cycle start is presented
    task automatic run_manual(input logic [2:0] ch, input logic wr, input logic [15:0] cv,
                              input logic [15:0] word, input int poke,
                              output int lat, output logic [3:0] cs_seen);
        sens_word = word;
        @(negedge clk);
        ch_sel = ch; cmd_wr = wr; cmd = cv; start = 1'b1;
        lat = 0; cs_seen = 4'hF;
        while (lat < 400) begin
            @(posedge clk); lat++; #1;
            if (lat == 1) begin start = 1'b0; cs_seen = cs_n; end
            if (poke > 0 && lat == poke) begin start = 1'b1; ch_sel = 3'd1; end
            if (poke > 0 && lat == poke + 1) begin start = 1'b0; ch_sel = ch; end
            if (rd_valid) break;
        end
    endtask

    // Count cycles with any bus or result activity
    task automatic quiet(input int cycles, output int act);
        act = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (busy || !(&cs_n) || rd_valid) act++;
        end
    endtask

    task automatic wait_busy(input int bound, input logic poke, output int n);
        n = 0;
        while (n < bound) begin
            @(posedge clk); n++; #1;
            if (poke && n == 1) begin start = 1'b1; ch_sel = 3'd3; end
            if (n == 2) start = 1'b0;
            if (busy) break;
        end
    endtask

    task automatic wait_rdv(input int bound, output int n);
        n = 0;
        while (n < bound) begin
            @(posedge clk); n++; #1;
            if (rd_valid) break;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int act;
        int n;
        logic [3:0] cs_seen;
        logic [3:0] exp_cs;

        reset_n = 1'b0; start = 1'b0; ch_sel = 3'd0; cmd_wr = 1'b0;
        cmd = 16'h0000; auto_en = 1'b0;
`ifdef TEMP_ALARM_EN
        thr_hi = 16'sh7FFF; thr_lo = -16'sh8000; alarm_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cs_n", 32'(cs_n), 32'hF);
        check("rst_sc", 32'(sc), 32'd0);
        check("rst_sio_o", 32'(sio_o), 32'd0);
        check("rst_sio_oe", 32'(sio_oe), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_ch", 32'(rd_ch), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        @(negedge clk) reset_n = 1'b1;

        // Plain read on channel 1
        run_manual(3'd1, 1'b0, 16'h0000, 16'h0C80, 0, lat, cs_seen);
        check("rd1_latency", 32'(lat), 32'd69);
        check("rd1_cs_n", 32'(cs_seen), 32'hD);
        check("rd1_sc_pulses", 32'(rises), 32'd16);
        check("rd1_data", 32'(rd_data), 32'h0C80);
        check("rd1_ch", 32'(rd_ch), 32'd1);
        check("rd1_oe", 32'(oe_bad), 32'd0);
        check("rd1_busy_end", 32'(busy), 32'd0);
        check("rd1_cs_end", 32'(cs_n), 32'hF);
        @(posedge clk); #1;
        check("rd1_valid_pulse", 32'(rd_valid), 32'd0);

        // Read + write, all-ones command
        run_manual(3'd0, 1'b1, 16'hFFFF, 16'h8001, 0, lat, cs_seen);
        check("rw1_latency", 32'(lat), 32'd133);
        check("rw1_cs_n", 32'(cs_seen), 32'hE);
        check("rw1_sc_pulses", 32'(rises), 32'd32);
        check("rw1_cmd", 32'(cmd_cap), 32'hFFFF);
        check("rw1_oe", 32'(oe_bad), 32'd0);
        check("rw1_data", 32'(rd_data), 32'h8001);
        check("rw1_sio_oe_end", 32'(sio_oe), 32'd0);

        // Read + write, mixed command pattern for bit ordering
        run_manual(3'd3, 1'b1, 16'h5A3C, 16'h7FFE, 0, lat, cs_seen);
        check("rw2_latency", 32'(lat), 32'd133);
        check("rw2_cs_n", 32'(cs_seen), 32'h7);
        check("rw2_cmd", 32'(cmd_cap), 32'h5A3C);
        check("rw2_data", 32'(rd_data), 32'h7FFE);
        check("rw2_ch", 32'(rd_ch), 32'd3);

        // start while busy is ignored
        run_manual(3'd2, 1'b0, 16'h0000, 16'h1234, 10, lat, cs_seen);
        check("busy_latency", 32'(lat), 32'd69);
        check("busy_ch", 32'(rd_ch), 32'd2);
        check("busy_data", 32'(rd_data), 32'h1234);
        quiet(150, act);
        check("busy_no_queue", 32'(act), 32'd0);

        // Out-of-range channels are ignored
        @(negedge clk) begin start = 1'b1; ch_sel = 3'd4; end
        @(negedge clk) start = 1'b0;
        quiet(60, act);
        check("ch4_ignored", 32'(act), 32'd0);
        @(negedge clk) begin start = 1'b1; ch_sel = 3'd5; end
        @(negedge clk) start = 1'b0;
        quiet(60, act);
        check("ch5_ignored", 32'(act), 32'd0);

        // Reset during READ while SC is high
        sens_word = 16'hABCD;
        @(negedge clk) begin start = 1'b1; ch_sel = 3'd1; cmd_wr = 1'b0; end
        @(negedge clk) start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_sc", 32'(sc), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_cs_n", 32'(cs_n), 32'hF);
        check("arst_sc", 32'(sc), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        run_manual(3'd2, 1'b0, 16'h0000, 16'h0C80, 0, lat, cs_seen);
        check("post_rst_latency", 32'(lat), 32'd69);
        check("post_rst_data", 32'(rd_data), 32'h0C80);

        // Reset during WRITE drops the output enable immediately
        sens_word = 16'h0000;
        @(negedge clk) begin start = 1'b1; ch_sel = 3'd0; cmd_wr = 1'b1; cmd = 16'h00FF; end
        @(negedge clk) start = 1'b0;
        repeat (69) @(negedge clk);
        check("pre_rst_oe", 32'(sio_oe), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_oe", 32'(sio_oe), 32'd0);
        check("arst_cs_w", 32'(cs_n), 32'hF);
        @(negedge clk) begin reset_n = 1'b1; cmd_wr = 1'b0; end

        // Round-robin polling; a start during auto mode must not launch
        @(negedge clk) auto_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_busy(300, (k == 1), n);
            check("poll_spacing", 32'(n), 32'd100);
            exp_cs = 4'hF;
            exp_cs[k % 4] = 1'b0;
            check("poll_cs_n", 32'(cs_n), 32'(exp_cs));
            if (k == 4) auto_en = 1'b0;
            wait_rdv(200, n);
            check("poll_latency", 32'(n), 32'd68);
            check("poll_rd_ch", 32'(rd_ch), 32'(k % 4));
        end
        quiet(300, act);
        check("poll_stopped", 32'(act), 32'd0);

`ifdef TEMP_ALARM_EN
        thr_hi = 16'sh0C00;
        run_manual(3'd2, 1'b0, 16'h0000, 16'h0C80, 0, lat, cs_seen);
        @(posedge clk); #1;
        check("alarm_set", 32'(alarm), 32'h4);
        @(negedge clk) alarm_clr = 1'b1;
        @(posedge clk); #1;
        alarm_clr = 1'b0;
        check("alarm_clr", 32'(alarm), 32'h0);
        run_manual(3'd2, 1'b0, 16'h0000, 16'h0100, 0, lat, cs_seen);
        @(posedge clk); #1;
        check("alarm_in_range", 32'(alarm), 32'h0);
`else
        check("alarm_tied", 32'(alarm), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/temp_sensor_3wire_ctrl.md
Name: temp_sensor_3wire_ctrl

Overview:
Parametrised 3-wire serial (CS_N/SC/SIO) temperature-sensor controller, successor to the single-sensor fixed-format controller in the DECA temperature subsystem. Supports NUM_CH sensors on a shared SC/SIO bus with per-sensor chip selects, configurable word widths and SC rate, optional command write-back, and free-running round-robin polling. Sits between the platform's Avalon-side register wrapper and the board pins; the tri-state SIO buffer is instantiated at top level.

Parameters:
CLK_DIV, 25, clk_50 cycles per SC half-period (min 2); SC = 1 MHz at default
DATA_W, 16, read word width in bits, MSB first
CMD_W, 16, command word width in bits, MSB first
NUM_CH, 4, number of sensors / chip selects (1..8)
POLL_CYCLES, 5000000, clk_50 cycles between polled transactions in auto mode (100 ms)

Ports:
clk_50  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request, sampled only when busy=0 and auto_en=0
ch_sel  in  3  channel for a manual transaction, sampled with start
cmd_wr  in  1  append command write phase, sampled with start (auto mode: always 0)
cmd  in  CMD_W  command word, sampled with start
auto_en  in  1  enable round-robin polling of channels 0..NUM_CH-1
busy  out  1  transaction in progress
cs_n  out  NUM_CH  active-low chip selects, at most one low
sc  out  1  serial clock, idles low
sio_o  out  1  serial data out
sio_oe  out  1  SIO output enable (1 only during write phase)
sio_i  in  1  serial data in from pad
rd_data  out  DATA_W  last captured word
rd_ch  out  3  channel of rd_data
rd_valid  out  1  one-cycle strobe, rd_data/rd_ch updated same cycle
alarm  out  NUM_CH  sticky per-channel alarm (ALARM_EN only; else tied 0)

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, cs_n=all 1, sc=0, sio_o=0, sio_oe=0, rd_data=0, rd_ch=0, rd_valid=0, alarm=0, poll counter=0, channel pointer=0.
- FSM: IDLE -> SETUP -> READ -> [WRITE] -> HOLD -> IDLE.
- IDLE: start (auto_en=0) or poll counter reaching POLL_CYCLES-1 (auto_en=1) launches; busy=1 and cs_n[ch]=0 on the next edge. ch_sel>=NUM_CH: request ignored, busy stays 0.
- SETUP: CLK_DIV cycles, sc low.
- READ: DATA_W bits; per bit, sc low CLK_DIV cycles then high CLK_DIV cycles; sio_i sampled into shift register on the cycle sc goes high. Duration DATA_W*2*CLK_DIV.
- WRITE (cmd_wr=1 only): sio_oe=1 from WRITE entry; sio_o updates on each sc falling edge (first bit at entry), MSB first; duration CMD_W*2*CLK_DIV; sio_oe=0 on exit.
- HOLD: sc low, CLK_DIV cycles; on exit cs_n=all 1, busy=0, rd_valid=1 for one cycle, rd_data/rd_ch updated.
- Manual total latency start->rd_valid: 1+CLK_DIV*(2+2*DATA_W[+2*CMD_W]) cycles.
- Auto mode: counter counts only in IDLE, clears on launch; channel pointer increments after each transaction, wraps NUM_CH-1 -> 0. start ignored while auto_en=1.
- auto_en deasserted mid-transaction: current transaction completes; no further polls.
- start while busy=1: ignored, no queuing.
- Reset mid-transaction: cs_n released and sio_oe=0 immediately (asynchronous).

Optional Feature:
Macro TEMP_ALARM_EN. With it: extra inputs thr_hi, thr_lo (DATA_W, signed) and alarm_clr (1, one-cycle); on each rd_valid, alarm[rd_ch] sets if signed rd_data > thr_hi or < thr_lo; alarm_clr clears all bits, with set winning on a same-cycle collision. Without it: no extra ports, alarm tied to 0.

Test Plan:
- Manual read, CLK_DIV=2, ch_sel=1, sensor model returns 0x0C80 -> cs_n=4'b1101 during transfer, exactly 16 sc pulses, rd_valid at start+69 cycles, rd_data=0x0C80, rd_ch=1.
- Manual read+write, cmd=0xFFFF, cmd_wr=1 -> 32 sc pulses; sio_oe high only during the last 16; model captures 0xFFFF; rd_valid at start+133.
- auto_en=1, POLL_CYCLES=100, NUM_CH=4 -> cs_n sequence ch0,1,2,3,0; rd_ch matches; polls spaced 100 idle cycles.
- start during busy and ch_sel=5 in IDLE -> both ignored, no cs_n activity, no rd_valid.
- reset_n low mid-READ -> cs_n=all 1, sc=0, busy=0 asynchronously; next start completes normally.
- TEMP_ALARM_EN, thr_hi=0x0C00, read 0x0C80 on ch2 -> alarm=4'b0100; alarm_clr -> 0; read 0x0100 -> stays 0.
